// File: rtl/rs_write_codifier_if.sv
// Handshake bundle between a symbol source, the RS(7,3) encoder and its sink.
// The slave modport is the encoder's view; master is the view of whoever drives it.
interface rs_write_codifier_if;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_sym;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_sym;
  logic       out_parity;
  logic       out_last;

  modport master (
    output in_valid, in_sym, out_ready,
    input  in_ready, out_valid, out_sym, out_parity, out_last
  );

  modport slave (
    input  in_valid, in_sym, out_ready,
    output in_ready, out_valid, out_sym, out_parity, out_last
  );
endinterface

// File: rtl/rs_write_codifier.sv
// Systematic RS(7,3) encoder over GF(8), field polynomial x^3+x+1.
// Three message symbols pass straight through, then the four remainder
// symbols of m(x)*x^4 mod g(x) are shifted out of a serial LFSR divider,
// with g(x) = x^4 + 3x^3 + x^2 + 2x + 3.
module rs_write_codifier (
  input  logic                 clk,
  input  logic                 rst_n,
  rs_write_codifier_if.slave   bus
);

  typedef enum logic {DATA, PARITY} state_t;

  state_t     r_state;
  logic [1:0] r_dcnt;
  logic [1:0] r_pcnt;
  logic [2:0] r_par3, r_par2, r_par1, r_par0;

  state_t     w_stateNext;
  logic [1:0] w_dcntNext;
  logic [1:0] w_pcntNext;
  logic [2:0] w_par3Next, w_par2Next, w_par1Next, w_par0Next;
  logic [2:0] w_fb;
  logic [2:0] w_fbMul2;
  logic [2:0] w_fbMul3;

  // Multiply by alpha (x): shift left and fold x^3 back as x+1.
  function automatic logic [2:0] gfMulAlpha(input logic [2:0] a);
    return {a[1], a[0] ^ a[2], a[2]};
  endfunction

  // Multiply by alpha^3 = alpha + 1.
  function automatic logic [2:0] gfMul3(input logic [2:0] a);
    return gfMulAlpha(a) ^ a;
  endfunction

  assign w_fb     = bus.in_sym ^ r_par3;
  assign w_fbMul2 = gfMulAlpha(w_fb);
  assign w_fbMul3 = gfMul3(w_fb);

  // State, counters and divider registers load their next values; reset
  // discards any partial codeword at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= DATA;
      r_dcnt  <= 2'd0;
      r_pcnt  <= 2'd0;
      r_par3  <= 3'd0;
      r_par2  <= 3'd0;
      r_par1  <= 3'd0;
      r_par0  <= 3'd0;
    end else begin
      r_state <= w_stateNext;
      r_dcnt  <= w_dcntNext;
      r_pcnt  <= w_pcntNext;
      r_par3  <= w_par3Next;
      r_par2  <= w_par2Next;
      r_par1  <= w_par1Next;
      r_par0  <= w_par0Next;
    end
  end

  // Next-state and output decode: pass-through with LFSR update in DATA,
  // plain register shift-out in PARITY; nothing moves without a handshake.
  always_comb begin
    w_stateNext    = r_state;
    w_dcntNext     = r_dcnt;
    w_pcntNext     = r_pcnt;
    w_par3Next     = r_par3;
    w_par2Next     = r_par2;
    w_par1Next     = r_par1;
    w_par0Next     = r_par0;
    bus.in_ready   = 1'b0;
    bus.out_valid  = 1'b0;
    bus.out_sym    = 3'd0;
    bus.out_parity = 1'b0;
    bus.out_last   = 1'b0;

    case (r_state)
      DATA: begin
        bus.in_ready  = bus.out_ready;
        bus.out_valid = bus.in_valid;
        bus.out_sym   = bus.in_sym;
        if (bus.in_valid && bus.out_ready) begin
          w_par3Next = r_par2 ^ w_fbMul3;
          w_par2Next = r_par1 ^ w_fb;
          w_par1Next = r_par0 ^ w_fbMul2;
          w_par0Next = w_fbMul3;
          if (r_dcnt == 2'd2) begin
            w_stateNext = PARITY;
            w_dcntNext  = 2'd0;
            w_pcntNext  = 2'd0;
          end else begin
            w_dcntNext = r_dcnt + 2'd1;
          end
        end
      end
      PARITY: begin
        bus.out_valid  = 1'b1;
        bus.out_sym    = r_par3;
        bus.out_parity = 1'b1;
        bus.out_last   = (r_pcnt == 2'd3);
        if (bus.out_ready) begin
          w_par3Next = r_par2;
          w_par2Next = r_par1;
          w_par1Next = r_par0;
          w_par0Next = 3'd0;
          if (r_pcnt == 2'd3) begin
            w_stateNext = DATA;
            w_dcntNext  = 2'd0;
            w_pcntNext  = 2'd0;
          end else begin
            w_pcntNext = r_pcnt + 2'd1;
          end
        end
      end
    endcase
  end

endmodule

// File: tb/tb_rs_write_codifier.sv
// Self-checking bench for the RS(7,3) encoder: directed codewords, streaming,
// backpressure, input gaps, mid-codeword reset and random codewords checked
// against a polynomial long-division reference model.
module tb_rs_write_codifier;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  rs_write_codifier_if bus ();

  rs_write_codifier dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  localparam logic [2:0] EXP_TAB [0:6] = '{3'd1, 3'd2, 3'd4, 3'd3, 3'd6, 3'd7, 3'd5};
  localparam logic [2:0] GEN [0:4]     = '{3'd3, 3'd2, 3'd1, 3'd3, 3'd1};
  localparam int KNOWN_CW [0:3][0:6] = '{
    '{1, 0, 0, 6, 1, 6, 7},
    '{0, 0, 1, 3, 1, 2, 3},
    '{1, 0, 1, 5, 0, 4, 4},
    '{0, 0, 0, 0, 0, 0, 0}
  };

  logic [2:0] obsSym [$];
  bit         obsPar [$];
  bit         obsLast [$];
  int         obsCyc [$];
  logic [4:0] stallPrev [$];
  logic [4:0] stallNow [$];
  bit         parInReady [$];
  bit         timedOut;

  // GF(8) multiply through discrete logarithms.
  function automatic logic [2:0] refMul(input logic [2:0] a, input logic [2:0] b);
    int la = 0;
    int lb = 0;
    if (a == 3'd0 || b == 3'd0) return 3'd0;
    for (int i = 0; i < 7; i++) begin
      if (EXP_TAB[i] == a) la = i;
      if (EXP_TAB[i] == b) lb = i;
    end
    return EXP_TAB[(la + lb) % 7];
  endfunction

  // Remainder of a degree-6 polynomial (index = power of x) modulo g(x),
  // returned highest power first as {x^3, x^2, x^1, x^0}.
  function automatic logic [11:0] polyMod(input logic [2:0] p [0:6]);
    logic [2:0] rem [0:6];
    logic [2:0] coef;
    for (int i = 0; i < 7; i++) rem[i] = p[i];
    for (int i = 6; i >= 4; i--) begin
      coef = rem[i];
      for (int j = 0; j <= 4; j++) rem[i - 4 + j] = rem[i - 4 + j] ^ refMul(coef, GEN[j]);
    end
    return {rem[3], rem[2], rem[1], rem[0]};
  endfunction

  // Systematic codeword for a message: message symbols, then remainder symbols.
  function automatic logic [2:0] refSym(input logic [2:0] m0, input logic [2:0] m1,
                                        input logic [2:0] m2, input int k);
    logic [2:0]  p [0:6];
    logic [11:0] r;
    for (int i = 0; i < 7; i++) p[i] = 3'd0;
    p[6] = m0;
    p[5] = m1;
    p[4] = m2;
    r = polyMod(p);
    case (k)
      0: return m0;
      1: return m1;
      2: return m2;
      3: return r[11:9];
      4: return r[8:6];
      5: return r[5:3];
      default: return r[2:0];
    endcase
  endfunction

  // Drives a symbol stream and records every output handshake, parity stall
  // and in_ready seen during parity.
  task automatic stream(input logic [2:0] msgs [$], input int readyPct, input int validPct,
                        input int stopAt, input int budget);
    int         idx = 0;
    int         cyc = 0;
    bit         prevStall = 1'b0;
    logic [4:0] prevObs = 5'd0;
    obsSym.delete();
    obsPar.delete();
    obsLast.delete();
    obsCyc.delete();
    stallPrev.delete();
    stallNow.delete();
    parInReady.delete();
    timedOut = 1'b0;
    while (obsSym.size() < stopAt) begin
      if (cyc >= budget) begin
        timedOut = 1'b1;
        break;
      end
      @(negedge clk);
      bus.in_valid  = (idx < msgs.size()) && ($urandom_range(0, 99) < validPct);
      bus.in_sym    = bus.in_valid ? msgs[idx] : 3'($urandom);
      bus.out_ready = ($urandom_range(0, 99) < readyPct);
      #1;
      if (prevStall) begin
        stallPrev.push_back(prevObs);
        stallNow.push_back({bus.out_last, bus.out_parity, bus.out_sym});
      end
      prevStall = bus.out_valid && !bus.out_ready && bus.out_parity;
      prevObs   = {bus.out_last, bus.out_parity, bus.out_sym};
      if (bus.out_parity) parInReady.push_back(bus.in_ready);
      if (bus.in_valid && bus.in_ready) idx++;
      if (bus.out_valid && bus.out_ready) begin
        obsSym.push_back(bus.out_sym);
        obsPar.push_back(bus.out_parity);
        obsLast.push_back(bus.out_last);
        obsCyc.push_back(cyc);
      end
      cyc++;
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.in_sym    = 3'd0;
    bus.out_ready = 1'b0;
  endtask

  // Reset-state outputs: pass-through in DATA, no parity or last flag.
  task automatic test_reset();
    rst_n         = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_sym    = 3'd5;
    bus.out_ready = 1'b1;
    #1;
    total++;
    if (bus.out_valid !== 1'b1 || bus.out_sym !== 3'd5 || bus.in_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL reset_passthru: got valid=%b sym=%0d ready=%b expected 1/5/1",
               bus.out_valid, bus.out_sym, bus.in_ready);
    end
    total++;
    if (bus.out_parity !== 1'b0 || bus.out_last !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_flags: got parity=%b last=%b expected 0/0", bus.out_parity, bus.out_last);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    total++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_idle: got valid=%b ready=%b expected 0/0", bus.out_valid, bus.in_ready);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Known codewords with continuous flow.
  task automatic test_single();
    logic [2:0] msgs [$];
    for (int v = 0; v < 4; v++) begin
      msgs = '{3'(KNOWN_CW[v][0]), 3'(KNOWN_CW[v][1]), 3'(KNOWN_CW[v][2])};
      stream(msgs, 100, 100, 7, 100);
      total++;
      if (obsSym.size() != 7) begin
        bad++;
        $display("[TB] FAIL single%0d_count: got %0d symbols expected 7", v, obsSym.size());
        continue;
      end
      for (int k = 0; k < 7; k++) begin
        total++;
        if (obsSym[k] !== 3'(KNOWN_CW[v][k]) || obsPar[k] !== (k >= 3) || obsLast[k] !== (k == 6)) begin
          bad++;
          $display("[TB] FAIL single%0d_sym%0d: got sym=%0d par=%b last=%b expected sym=%0d par=%b last=%b",
                   v, k, obsSym[k], obsPar[k], obsLast[k], KNOWN_CW[v][k], k >= 3, k == 6);
        end
      end
      total++;
      if (obsCyc[6] - obsCyc[0] != 6) begin
        bad++;
        $display("[TB] FAIL single%0d_cycles: got %0d expected 6", v, obsCyc[6] - obsCyc[0]);
      end
    end
  endtask

  // Two codewords streamed with no bubble between them.
  task automatic test_back_to_back();
    logic [2:0] msgs [$];
    int lastCount;
    msgs = '{3'd1, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1};
    stream(msgs, 100, 100, 14, 200);
    total++;
    if (obsSym.size() != 14) begin
      bad++;
      $display("[TB] FAIL b2b_count: got %0d symbols expected 14", obsSym.size());
      return;
    end
    for (int b = 0; b < 2; b++) begin
      lastCount = 0;
      for (int k = 0; k < 7; k++) begin
        total++;
        if (obsSym[b * 7 + k] !== 3'(KNOWN_CW[b][k])) begin
          bad++;
          $display("[TB] FAIL b2b_blk%0d_sym%0d: got %0d expected %0d", b, k, obsSym[b * 7 + k], KNOWN_CW[b][k]);
        end
        if (obsLast[b * 7 + k]) lastCount++;
      end
      total++;
      if (lastCount != 1 || obsLast[b * 7 + 6] !== 1'b1) begin
        bad++;
        $display("[TB] FAIL b2b_blk%0d_last: got count=%0d expected 1 on symbol 7", b, lastCount);
      end
    end
    total++;
    if (obsCyc[13] - obsCyc[0] != 13) begin
      bad++;
      $display("[TB] FAIL b2b_bubble: got span %0d expected 13", obsCyc[13] - obsCyc[0]);
    end
  endtask

  // Random downstream stalls must not alter the codeword or stalled outputs.
  task automatic test_backpressure();
    logic [2:0] msgs [$];
    msgs = '{3'd1, 3'd0, 3'd1};
    for (int rep = 0; rep < 3; rep++) begin
      stream(msgs, 50, 100, 7, 500);
      total++;
      if (obsSym.size() != 7) begin
        bad++;
        $display("[TB] FAIL bp%0d_count: got %0d symbols expected 7", rep, obsSym.size());
        continue;
      end
      for (int k = 0; k < 7; k++) begin
        total++;
        if (obsSym[k] !== 3'(KNOWN_CW[2][k]) || obsLast[k] !== (k == 6)) begin
          bad++;
          $display("[TB] FAIL bp%0d_sym%0d: got sym=%0d last=%b expected sym=%0d last=%b",
                   rep, k, obsSym[k], obsLast[k], KNOWN_CW[2][k], k == 6);
        end
      end
      for (int s = 0; s < stallPrev.size(); s++) begin
        total++;
        if (stallNow[s] !== stallPrev[s]) begin
          bad++;
          $display("[TB] FAIL bp%0d_stall%0d: got %h expected %h", rep, s, stallNow[s], stallPrev[s]);
        end
      end
      for (int s = 0; s < parInReady.size(); s++) begin
        total++;
        if (parInReady[s] !== 1'b0) begin
          bad++;
          $display("[TB] FAIL bp%0d_inready%0d: got %b expected 0", rep, s, parInReady[s]);
        end
      end
    end
  endtask

  // Gaps in in_valid between message symbols leave the parity unchanged.
  task automatic test_input_gaps();
    logic [2:0] msgs [$];
    msgs = '{3'd0, 3'd0, 3'd1};
    stream(msgs, 100, 40, 7, 500);
    total++;
    if (obsSym.size() != 7) begin
      bad++;
      $display("[TB] FAIL gaps_count: got %0d symbols expected 7", obsSym.size());
      return;
    end
    for (int k = 0; k < 7; k++) begin
      total++;
      if (obsSym[k] !== 3'(KNOWN_CW[1][k]) || obsPar[k] !== (k >= 3)) begin
        bad++;
        $display("[TB] FAIL gaps_sym%0d: got sym=%0d par=%b expected sym=%0d par=%b",
                 k, obsSym[k], obsPar[k], KNOWN_CW[1][k], k >= 3);
      end
    end
  endtask

  // Reset mid-codeword (in DATA, then in PARITY) and a clean codeword afterwards.
  task automatic test_reset_mid();
    logic [2:0] msgs [$];
    logic [2:0] clean [$];
    msgs  = '{3'd1, 3'd0, 3'd1};
    clean = '{3'd0, 3'd0, 3'd1};
    for (int variant = 0; variant < 2; variant++) begin
      stream(msgs, 100, 100, (variant == 0) ? 2 : 4, 100);
      #1;
      total++;
      if (bus.out_parity !== (variant == 1)) begin
        bad++;
        $display("[TB] FAIL rstmid%0d_pre: got parity=%b expected %b", variant, bus.out_parity, variant == 1);
      end
      #1 rst_n = 1'b0;
      #1;
      total++;
      if (bus.out_parity !== 1'b0 || bus.out_valid !== 1'b0) begin
        bad++;
        $display("[TB] FAIL rstmid%0d_async: got parity=%b valid=%b expected 0/0",
                 variant, bus.out_parity, bus.out_valid);
      end
      @(negedge clk);
      rst_n = 1'b1;
      stream(clean, 100, 100, 7, 100);
      total++;
      if (obsSym.size() != 7) begin
        bad++;
        $display("[TB] FAIL rstmid%0d_count: got %0d symbols expected 7", variant, obsSym.size());
        continue;
      end
      for (int k = 0; k < 7; k++) begin
        total++;
        if (obsSym[k] !== 3'(KNOWN_CW[1][k]) || obsLast[k] !== (k == 6)) begin
          bad++;
          $display("[TB] FAIL rstmid%0d_sym%0d: got sym=%0d last=%b expected sym=%0d last=%b",
                   variant, k, obsSym[k], obsLast[k], KNOWN_CW[1][k], k == 6);
        end
      end
    end
  endtask

  // Random messages under random flow control against the division model;
  // every received block must also be divisible by g(x), as a decoder expects.
  task automatic test_random_loopback();
    localparam int NBLK = 20;
    logic [2:0]  msgs [$];
    logic [2:0]  cw [0:6];
    logic [2:0]  expSym;
    for (int i = 0; i < NBLK * 3; i++) msgs.push_back(3'($urandom));
    stream(msgs, 70, 80, NBLK * 7, 3000);
    total++;
    if (obsSym.size() != NBLK * 7) begin
      bad++;
      $display("[TB] FAIL rand_count: got %0d symbols expected %0d", obsSym.size(), NBLK * 7);
      return;
    end
    for (int b = 0; b < NBLK; b++) begin
      for (int k = 0; k < 7; k++) begin
        expSym = refSym(msgs[b * 3], msgs[b * 3 + 1], msgs[b * 3 + 2], k);
        total++;
        if (obsSym[b * 7 + k] !== expSym || obsPar[b * 7 + k] !== (k >= 3) || obsLast[b * 7 + k] !== (k == 6)) begin
          bad++;
          $display("[TB] FAIL rand_blk%0d_sym%0d: got sym=%0d par=%b last=%b expected sym=%0d par=%b last=%b",
                   b, k, obsSym[b * 7 + k], obsPar[b * 7 + k], obsLast[b * 7 + k], expSym, k >= 3, k == 6);
        end
        cw[6 - k] = obsSym[b * 7 + k];
      end
      total++;
      if (polyMod(cw) !== 12'd0) begin
        bad++;
        $display("[TB] FAIL rand_blk%0d_syndrome: got remainder %h expected 000", b, polyMod(cw));
      end
    end
  endtask

  // Runs every scenario in order, then reports.
  initial begin
    bus.in_valid  = 1'b0;
    bus.in_sym    = 3'd0;
    bus.out_ready = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_input_gaps();
    test_reset_mid();
    test_random_loopback();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rs_write_codifier.md
# rs_write_codifier

Systematic Reed-Solomon RS(7,3) encoder over GF(2^3). It is the transmit-side counterpart of the RS write decodifier. It accepts a stream of 3-bit message symbols, passes them through unchanged, and then appends 4 parity symbols computed by a serial LFSR divider. It sits upstream of the decoder, so encoder output can be looped straight into it, with valid/ready flow control on both sides.

## Interface
- Parameters: none. The field, code and generator are fixed:
  - Field: primitive polynomial x^3+x+1.
  - Element values: α=2, α^2=4, α^3=3, α^4=6, α^5=7, α^6=5.
  - Generator: g(x) = x^4 + α^3·x^3 + x^2 + α·x + α^3, so coefficients g3=3, g2=1, g1=2, g0=3.
- Clock and reset: one clock; reset is asynchronous and active-low.
- Ports:
  - clk  in  1  rising-edge clock
  - rst_n  in  1  asynchronous active-low reset
  - in_valid  in  1  in_sym carries a message symbol
  - in_ready  out  1  encoder accepts in_sym this cycle
  - in_sym  in  3  message symbol, highest-order symbol first
  - out_valid  out  1  out_sym is valid
  - out_ready  in  1  downstream accepts out_sym
  - out_sym  out  3  codeword symbol
  - out_parity  out  1  high while out_sym is a parity symbol
  - out_last  out  1  high on the 7th (final) codeword symbol

## Operation
- State machine with two states:
  - DATA: a 2-bit counter dcnt runs 0..2.
  - PARITY: a 2-bit counter pcnt runs 0..3.
- Registers: parity r3, r2, r1, r0 (3 bits each), state, dcnt, pcnt.
- DATA state, combinational pass-through:
  - out_valid = in_valid, out_sym = in_sym, in_ready = out_ready.
  - out_parity = 0, out_last = 0.
- A data handshake occurs when in_valid and out_ready are both high. On each data handshake:
  - fb = in_sym XOR r3.
  - r3 ← r2 XOR gmul(3,fb); r2 ← r1 XOR fb; r1 ← r0 XOR gmul(2,fb); r0 ← gmul(3,fb).
  - dcnt increments.
  - On the handshake with dcnt==2: go to PARITY, set pcnt=0.
- PARITY state:
  - in_ready = 0, out_valid = 1, out_sym = r3, out_parity = 1.
  - out_last = (pcnt==3).
- On each parity handshake (out_ready high): r3 ← r2, r2 ← r1, r1 ← r0, r0 ← 0, and pcnt increments.
- On the handshake with pcnt==3: go to DATA with dcnt=0. All parity registers are zero at this point.
- gmul is a combinational GF(8) multiply by a constant, reduced modulo x^3+x+1.
- No idle state; back-to-back codewords need no bubble.
- in_sym is not checked for X when in_valid is low. Parity registers change only on handshakes.

## Timing
- Reset values: state=DATA, dcnt=0, pcnt=0, r3..r0=0. Outputs in_ready, out_valid and out_sym follow the inputs combinationally; out_parity=0; out_last=0.
- Data path latency is 0 cycles, since data symbols are combinational pass-through.
- Parity:
  - The first parity symbol is presented in the cycle after the 3rd data handshake.
  - The 4 parity symbols take a minimum of 4 cycles.
  - Full codeword throughput is 7 cycles minimum.
- Stall:
  - While out_ready is low, out_sym, out_parity and out_last in PARITY hold stable.
  - No register changes while stalled.
  - In DATA, a symbol is consumed only when out_ready is high.
- A gap with in_valid low in DATA leaves all state unchanged.
- Reset asserted mid-codeword discards the partial codeword immediately, asynchronously. After release, the next accepted symbol is message symbol 0.
- out_valid and out_ready being high together in the same cycle as the DATA→PARITY transition does not pull in a 4th data symbol. in_ready is already 0 in the next cycle.

## Test plan
- Single codewords, continuous flow control, in symbol order:
  - Message 1,0,0 → out 1,0,0,6,1,6,7.
  - Message 0,0,1 → out 0,0,1,3,1,2,3.
  - Message 1,0,1 → out 1,0,1,5,0,4,4.
  - Message 0,0,0 → all zeros.
  - In every case out_parity is high on symbols 4..7 and out_last is high only on symbol 7.
- Back-to-back: stream messages 1,0,0 then 0,0,1 with in_valid held high → 14 symbols as above with no bubble cycles. Each block's out_last is high exactly once.
- Backpressure: random out_ready (about 50%) during message 1,0,1 → identical symbol sequence 1,0,1,5,0,4,4. out_sym is stable whenever out_valid is high and out_ready is low. in_ready is 0 throughout PARITY.
- Input gaps: in_valid toggling between data symbols → parity unchanged, still 3,1,2,3 for 0,0,1.
- Reset mid-operation: assert rst_n low after 2 data symbols or after 1 parity symbol, then send 0,0,1 → clean codeword 0,0,1,3,1,2,3 with state=DATA and dcnt=0.
- Loopback: random messages through this block into the RS write decodifier → decoded data matches the input message and no error is flagged.
